// File: rtl/calc_hist.sv
// Button-driven accumulator calculator: one ALU operation per execute press,
// circular undo history of prior accumulator values, and signed-overflow flag.
module calc_hist #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     btnu,
    input  logic                     btnc,
    input  logic                     btnl,
    input  logic                     btnr,
    input  logic                     btnd,
    input  logic                     btn_undo,
    input  logic [WIDTH-1:0]         sw,
    output logic [WIDTH-1:0]         led,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   hist_cnt,
    output logic                     hist_full,
    output logic                     hist_empty
);

    localparam int SHW = $clog2(WIDTH);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_SLT = 3'b100,
        OP_LSL = 3'b101,
        OP_SRA = 3'b110,
        OP_XOR = 3'b111
    } op_e;

    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_wptr;
    logic             r_btnd_q;
    logic             r_undo_q;
    logic [WIDTH-1:0] r_hist [DEPTH];

    logic             w_exec;
    logic             w_undo;
    op_e              w_op;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_res_ovf;
    logic [PW-1:0]    w_prev_ptr;
    logic [WIDTH-1:0] w_hist_rd;

    // Undo only acts on a fresh edge that does not collide with an execute edge.
    assign w_exec     = btnd & ~r_btnd_q;
    assign w_undo     = btn_undo & ~r_undo_q & ~w_exec;
    assign w_op       = op_e'({btnl, btnc, btnr});
    assign w_shamt    = sw[SHW-1:0];
    assign w_prev_ptr = r_wptr - PW'(1);
    assign w_hist_rd  = r_hist[w_prev_ptr];

    // ALU result and signed overflow for the selected operation
    always_comb begin
        w_res     = {WIDTH{1'b0}};
        w_res_ovf = 1'b0;
        case (w_op)
            OP_AND: w_res = r_acc & sw;
            OP_OR:  w_res = r_acc | sw;
            OP_ADD: begin
                w_res     = r_acc + sw;
                w_res_ovf = (r_acc[WIDTH-1] == sw[WIDTH-1]) &&
                            (w_res[WIDTH-1] != r_acc[WIDTH-1]);
            end
            OP_SUB: begin
                w_res     = r_acc - sw;
                w_res_ovf = (r_acc[WIDTH-1] != sw[WIDTH-1]) &&
                            (w_res[WIDTH-1] != r_acc[WIDTH-1]);
            end
            OP_SLT: begin
                if ($signed(r_acc) < $signed(sw)) begin
                    w_res = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    w_res = {WIDTH{1'b0}};
                end
            end
            OP_LSL: w_res = r_acc << w_shamt;
            OP_SRA: w_res = $signed(r_acc) >>> w_shamt;
            OP_XOR: w_res = r_acc ^ sw;
            default: begin
                w_res     = {WIDTH{1'b0}};
                w_res_ovf = 1'b0;
            end
        endcase
    end

    // History storage; contents are not reset and only written on execute
    always_ff @(posedge clk) begin
        if (!btnu && w_exec) begin
            r_hist[r_wptr] <= r_acc;
        end
    end

    // Accumulator, overflow, history pointer/count and button edge registers
    always_ff @(posedge clk) begin
        if (btnu) begin
            r_acc    <= {WIDTH{1'b0}};
            r_ovf    <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_wptr   <= {PW{1'b0}};
            r_btnd_q <= 1'b1;
            r_undo_q <= 1'b1;
        end else begin
            r_btnd_q <= btnd;
            r_undo_q <= btn_undo;
            if (w_exec) begin
                r_acc  <= w_res;
                r_ovf  <= w_res_ovf;
                r_wptr <= r_wptr + PW'(1);
                if (r_cnt != CW'(DEPTH)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (w_undo && (r_cnt != {CW{1'b0}})) begin
                r_acc  <= w_hist_rd;
                r_ovf  <= 1'b0;
                r_wptr <= w_prev_ptr;
                r_cnt  <= r_cnt - CW'(1);
            end
        end
    end

    assign led        = r_acc;
    assign ovf        = r_ovf;
    assign hist_cnt   = r_cnt;
    assign hist_full  = (r_cnt == CW'(DEPTH));
    assign hist_empty = (r_cnt == {CW{1'b0}});

endmodule

// File: tb/tb_calc_hist.sv
// Self-checking bench for calc_hist: a reference model pushes expected state into
// a scoreboard queue on every driven action; entries are popped against the DUT.
module tb_calc_hist;

    logic        clk;
    logic        btnu;
    logic        btnc;
    logic        btnl;
    logic        btnr;
    logic        btnd;
    logic        btn_undo;
    logic [15:0] sw;
    logic [15:0] led;
    logic        ovf;
    logic [3:0]  hist_cnt;
    logic        hist_full;
    logic        hist_empty;

    calc_hist #(.WIDTH(16), .DEPTH(8)) dut (
        .clk        (clk),
        .btnu       (btnu),
        .btnc       (btnc),
        .btnl       (btnl),
        .btnr       (btnr),
        .btnd       (btnd),
        .btn_undo   (btn_undo),
        .sw         (sw),
        .led        (led),
        .ovf        (ovf),
        .hist_cnt   (hist_cnt),
        .hist_full  (hist_full),
        .hist_empty (hist_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] led;
        logic        ovf;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [15:0] m_acc;
    logic        m_ovf;
    int          m_cnt;
    int          m_wp;
    logic [15:0] m_hist [8];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] model_alu(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        int sa;
        int sb;
        int s;
        logic [15:0] r;
        logic o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        o = 1'b0;
        r = 16'h0000;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin s = sa + sb; r = 16'(s); o = (s > 32767) || (s < -32768); end
            3'd3: begin s = sa - sb; r = 16'(s); o = (s > 32767) || (s < -32768); end
            3'd4: r = (sa < sb) ? 16'd1 : 16'd0;
            3'd5: begin s = sa * (1 << int'(b[3:0])); r = 16'(s); end
            3'd6: begin s = sa >>> int'(b[3:0]); r = 16'(s); end
            3'd7: r = a ^ b;
            default: r = 16'h0000;
        endcase
        return {o, r};
    endfunction

    task automatic model_reset();
        m_acc = 16'h0000;
        m_ovf = 1'b0;
        m_cnt = 0;
        m_wp  = 0;
    endtask

    task automatic model_exec(input logic [2:0] op, input logic [15:0] b);
        logic [16:0] t;
        t = model_alu(op, m_acc, b);
        m_hist[m_wp] = m_acc;
        m_wp  = (m_wp + 1) % 8;
        m_acc = t[15:0];
        m_ovf = t[16];
        if (m_cnt < 8) m_cnt++;
    endtask

    task automatic model_undo();
        if (m_cnt > 0) begin
            m_wp  = (m_wp + 7) % 8;
            m_acc = m_hist[m_wp];
            m_ovf = 1'b0;
            m_cnt--;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.led = m_acc;
        e.ovf = m_ovf;
        e.cnt = 4'(m_cnt);
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".led"}, 32'(led), 32'(e.led));
            check({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
            check({tag, ".cnt"}, 32'(hist_cnt), 32'(e.cnt));
            check({tag, ".full"}, 32'(hist_full), 32'(e.cnt == 4'd8));
            check({tag, ".empty"}, 32'(hist_empty), 32'(e.cnt == 4'd0));
        end
    endtask

    task automatic expect_now(input string tag);
        push_exp();
        pop_cmp(tag);
    endtask

    task automatic set_op(input logic [2:0] op);
        btnl = op[2];
        btnc = op[1];
        btnr = op[0];
    endtask

    task automatic do_reset();
        btnu = 1'b1;
        step();
        btnu = 1'b0;
        model_reset();
        expect_now("reset");
        step();
    endtask

    task automatic do_exec(input string tag, input logic [2:0] op, input logic [15:0] b);
        set_op(op);
        sw   = b;
        btnd = 1'b1;
        step();
        model_exec(op, b);
        expect_now(tag);
        btnd = 1'b0;
        sw   = ~b;
        set_op(~op);
        step();
        expect_now({tag, ".rel"});
    endtask

    task automatic do_undo(input string tag);
        btn_undo = 1'b1;
        step();
        model_undo();
        expect_now(tag);
        btn_undo = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        btnu = 1'b0; btnc = 1'b0; btnl = 1'b0; btnr = 1'b0;
        btnd = 1'b0; btn_undo = 1'b0; sw = 16'h0000;
        model_reset();
        step();

        // reset then ADD
        do_reset();
        check("reset_led", 32'(led), 32'h0000);
        check("reset_empty", 32'(hist_empty), 32'd1);
        do_exec("add1", 3'b010, 16'h354a);
        check("add1_const", 32'(led), 32'h354a);
        check("add1_cnt", 32'(hist_cnt), 32'd1);

        // SUB with held button
        set_op(3'b011);
        sw = 16'h1234;
        btnd = 1'b1;
        step();
        model_exec(3'b011, 16'h1234);
        expect_now("sub");
        check("sub_const", 32'(led), 32'h2316);
        sw = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_now("held");
        end
        check("held_const", 32'(led), 32'h2316);
        check("held_cnt", 32'(hist_cnt), 32'd2);
        btnd = 1'b0;
        step();

        // undo sequence
        do_undo("undo1");
        check("undo1_const", 32'(led), 32'h354a);
        do_undo("undo2");
        check("undo2_const", 32'(led), 32'h0000);
        check("undo2_empty", 32'(hist_empty), 32'd1);
        do_undo("undo3");
        check("undo3_cnt", 32'(hist_cnt), 32'd0);

        // overflow
        do_exec("or7fff", 3'b001, 16'h7fff);
        do_exec("addovf", 3'b010, 16'h0001);
        check("ovf_led", 32'(led), 32'h8000);
        check("ovf_set", 32'(ovf), 32'd1);
        do_exec("andclr", 3'b000, 16'hffff);
        check("ovf_clr", 32'(ovf), 32'd0);

        // history wrap
        do_reset();
        for (int i = 0; i < 10; i++) do_exec("wrap_add", 3'b010, 16'h0001);
        check("wrap_led", 32'(led), 32'h000a);
        check("wrap_full", 32'(hist_full), 32'd1);
        for (int i = 0; i < 8; i++) do_undo("wrap_undo");
        check("wrap_undo_led", 32'(led), 32'h0002);
        check("wrap_undo_empty", 32'(hist_empty), 32'd1);
        do_undo("wrap_undo9");
        check("wrap_undo9_led", 32'(led), 32'h0002);

        // simultaneous exec and undo: exec wins, undo not deferred
        do_reset();
        do_exec("pre_or", 3'b001, 16'h0010);
        set_op(3'b010);
        sw = 16'h0005;
        btnd = 1'b1;
        btn_undo = 1'b1;
        step();
        model_exec(3'b010, 16'h0005);
        expect_now("simul");
        check("simul_const", 32'(led), 32'h0015);
        btnd = 1'b0;
        btn_undo = 1'b0;
        step();
        step();
        expect_now("simul_nodefer");

        // execute held through reset
        set_op(3'b010);
        sw = 16'h0003;
        btnd = 1'b1;
        btnu = 1'b1;
        step();
        btnu = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            expect_now("held_rst");
        end
        btnd = 1'b0;
        step();
        do_exec("post_rst", 3'b010, 16'h0003);
        check("post_rst_const", 32'(led), 32'h0003);

        // shift / compare corner cases
        do_exec("lsl_hi", 3'b101, 16'hfff4);
        do_exec("sra_neg", 3'b001, 16'h8000);
        do_exec("sra", 3'b110, 16'h0013);
        do_exec("slt_neg", 3'b100, 16'h0001);
        do_exec("slt_pos", 3'b100, 16'hffff);
        do_exec("sub_ovf_pre", 3'b001, 16'h8000);
        do_exec("sub_ovf", 3'b011, 16'h0001);

        // random mix of operations and undos
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_undo("rnd_undo");
            end else begin
                do_exec("rnd_exec", 3'($urandom_range(0, 7)), 16'($urandom()));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
